dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
Responder end of the core's data-memory access interface. It accepts one load or store request per transaction through a valid/ready handshake and services it after a fixed, parameterised latency. It returns read data or an error flag as a one-cycle response pulse. It also holds the memory-mapped 8-bit LED register. It sits in the MEM stage in place of a zero-latency data memory, so the core's stall logic sees a real multi-cycle memory.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the backing RAM (word index = addr[31:2]).
LATENCY, 2, cycles from the accept edge to the response pulse; legal range 1..15.
LED_ADDR, 32'hFFFF_FF00, word-aligned MMIO address of the LED register.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request this cycle
req_wen  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
req_funct3  input  3  RISC-V access size/sign (LB/LH/LW/LBU/LHU, SB/SH/SW)
rsp_valid  output  1  one-cycle response pulse
rsp_rdata  output  32  load result, sign/zero-extended; 0 for stores and errors
rsp_err  output  1  qualified by rsp_valid; misaligned, illegal funct3 or out of range
led  output  8  LED register

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: FSM=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, led=0, latency counter=0.
- RAM contents are not reset and are undefined until written.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid=1 at an edge, latch wen, addr, wdata and funct3, load counter=LATENCY-1, and go to WAIT (or straight to RESP if LATENCY=1).
  - If req_valid=0, stay in IDLE.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle; when it reaches 0, go to RESP.
- RESP:
  - rsp_valid=1 for exactly this one cycle, with rsp_rdata and rsp_err valid. req_ready=0.
  - A store commits (RAM or led) on the edge that leaves RESP.
  - Next state is IDLE.
- Latency: rsp_valid rises exactly LATENCY cycles after the accept edge. Back-to-back throughput is one request per LATENCY+1 cycles.
- No response backpressure: the consumer must sample in the RESP cycle.
- Requests presented while req_ready=0 are ignored and not queued. Request inputs are not sampled after accept.
- Decode (on the latched request):
  - funct3 legal for loads: 000, 001, 010, 100, 101. Legal for stores: 000, 001, 010. Anything else sets err.
  - Alignment: half accesses need addr[0]=0; word accesses need addr[1:0]=0. Otherwise err.
  - Range: addr==LED_ADDR selects the LED register. Otherwise addr[31:2] must be < DEPTH_WORDS, else err.
- Errored access: no RAM or led change, rsp_rdata=0, rsp_err=1.
- Loads:
  - Select the byte (addr[1:0]) or half (addr[1]) from the word.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW returns the full word.
- Stores:
  - Byte-enable merge into the addressed word: SB writes lane addr[1:0], SH writes lanes for addr[1], SW writes all four lanes.
  - Other bytes are unchanged.
- LED register:
  - Any legal-size store to LED_ADDR writes led<=wdata[7:0].
  - Any legal-size load from LED_ADDR returns {24'b0, led} with zero extension, regardless of sign.
- Reset mid-transaction (rst=1 in WAIT or RESP): abort to IDLE, no store commit, no rsp_valid on the following cycle, led=0.
- Simultaneous rst and req_valid: reset wins and the request is not accepted.

Test Plan:
- LATENCY=2. SW addr 0x10, data 0xDEADBEEF accepted at cycle 0 -> rsp_valid=1 at cycle 2, err=0, rdata=0, req_ready=0 in cycles 1-2, 1 in cycle 3. Then LW 0x10 -> rdata=0xDEADBEEF.
- After that word: LB 0x13 -> 0xFFFFFFDE. LBU 0x13 -> 0x000000DE. LH 0x10 -> 0xFFFFBEEF. LHU 0x12 -> 0x0000DEAD.
- SB 0x11 data 0x55 -> LW 0x10 returns 0xDEAD55EF. SH 0x12 data 0x1234 -> LW returns 0x123455EF.
- LW 0x12 (misaligned), SH 0x11, funct3=011, and LW at word index DEPTH_WORDS -> each gives rsp_err=1, rdata=0, with RAM and led unchanged.
- SW LED_ADDR data 0x000000A5 -> led=0xA5 after the RESP edge. LB LED_ADDR -> rdata=0x000000A5 (zero-extended).
- SW 0x20 data 0x1 accepted, then rst=1 in the WAIT cycle -> no rsp_valid, LW 0x20 later does not return 0x1 (pre-written 0x0 persists), led=0. Also hold req_valid=1 through a busy window -> exactly one response per accept.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request port, fixed-latency single-pulse response,
// word-addressed backing RAM with byte-lane stores, and a memory-mapped 8-bit LED register.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] LED_ADDR    = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [7:0]  led
);

  localparam int unsigned IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  CNT_LOAD    = 4'(LATENCY - 1);
  localparam logic [29:0] DEPTH_LIMIT = 30'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state;
  state_t state_next;
  logic [3:0] cnt;
  logic [3:0] cnt_next;

  logic        lat_wen;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [2:0]  lat_funct3;

  logic [31:0] mem [DEPTH_WORDS];

  logic             f3_legal;
  logic             misaligned;
  logic             is_led;
  logic             out_of_range;
  logic             acc_err;
  logic [IDX_W-1:0] idx;
  logic [31:0]      ram_word;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [31:0]      load_data;
  logic [3:0]       be;
  logic [31:0]      wlane;
  logic             commit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // The counter is loaded with LATENCY-1 on accept; the transition into RESP happens
  // on the same edge that brings it to zero, so RESP lands exactly LATENCY edges later.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    req_ready  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          cnt_next   = CNT_LOAD;
          state_next = (LATENCY <= 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt <= 4'd1) begin
          cnt_next   = 4'd0;
          state_next = RESP;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_wen    <= 1'b0;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
      lat_funct3 <= 3'd0;
    end else if (state == IDLE && req_valid) begin
      lat_wen    <= req_wen;
      lat_addr   <= req_addr;
      lat_wdata  <= req_wdata;
      lat_funct3 <= req_funct3;
    end
  end

  always_comb begin
    if (lat_wen) begin
      f3_legal = (lat_funct3 == 3'b000) || (lat_funct3 == 3'b001) || (lat_funct3 == 3'b010);
    end else begin
      f3_legal = (lat_funct3 == 3'b000) || (lat_funct3 == 3'b001) || (lat_funct3 == 3'b010) ||
                 (lat_funct3 == 3'b100) || (lat_funct3 == 3'b101);
    end
    misaligned   = ((lat_funct3[1:0] == 2'b01) && lat_addr[0]) ||
                   ((lat_funct3[1:0] == 2'b10) && (lat_addr[1:0] != 2'b00));
    is_led       = (lat_addr == LED_ADDR);
    out_of_range = !is_led && (lat_addr[31:2] >= DEPTH_LIMIT);
    acc_err      = !f3_legal || misaligned || out_of_range;
    idx          = lat_addr[IDX_W+1:2];
  end

  always_comb begin
    ram_word = mem[idx];
    byte_sel = 8'(ram_word >> {lat_addr[1:0], 3'b000});
    half_sel = lat_addr[1] ? ram_word[31:16] : ram_word[15:0];
    case (lat_funct3)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_data = ram_word;
      3'b100:  load_data = {24'd0, byte_sel};
      3'b101:  load_data = {16'd0, half_sel};
      default: load_data = 32'd0;
    endcase
  end

  // The LED register always reads back zero-extended, whatever the load's signedness.
  always_comb begin
    rsp_valid = (state == RESP);
    rsp_err   = (state == RESP) && acc_err;
    rsp_rdata = 32'd0;
    if (state == RESP && !acc_err && !lat_wen) begin
      rsp_rdata = is_led ? {24'd0, led} : load_data;
    end
  end

  always_comb begin
    case (lat_funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << lat_addr[1:0];
        wlane = {4{lat_wdata[7:0]}};
      end
      2'b01: begin
        be    = lat_addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{lat_wdata[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = lat_wdata;
      end
    endcase
    commit = (state == RESP) && lat_wen && !acc_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led <= 8'd0;
    end else if (commit && is_led) begin
      led <= lat_wdata[7:0];
    end
  end

  // RAM has no reset; an asserted rst still suppresses a pending commit.
  always_ff @(posedge clk) begin
    if (!rst && commit && !is_led) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[idx][8*i +: 8] <= wlane[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: latency/handshake timing, load extension, store merge,
// error decode, LED register, reset abort and held-valid throughput.
module tb_dmem_responder;

  localparam logic [31:0] LED_ADDR = 32'hFFFF_FF00;
  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [2:0]  req_funct3 = 3'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  led;

  int vectors = 0;
  int miscompares = 0;

  dmem_responder #(
    .DEPTH_WORDS(1024),
    .LATENCY(2),
    .LED_ADDR(LED_ADDR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_wen(req_wen),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_funct3(req_funct3),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .led(led)
  );

  always #5 clk = ~clk;

  // One transaction: present at a negedge, drop valid after the accept edge, then wait
  // (bounded) for the response pulse and report its contents and latency in cycles.
  task automatic do_txn(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3, output logic [31:0] rdata, output logic err,
                        output int lat);
    @(negedge clk);
    req_valid  = 1'b1;
    req_wen    = wen;
    req_addr   = addr;
    req_wdata  = wdata;
    req_funct3 = f3;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat   = 0;
    rdata = 32'd0;
    err   = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat   = i;
        rdata = rsp_rdata;
        err   = rsp_err;
        break;
      end
    end
    if (lat == 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL txn_timeout addr=%h: no rsp_valid within 20 cycles", addr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready got %b want 1", req_ready); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid got %b want 0", rsp_valid); end
    vectors++; if (rsp_rdata !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_rdata got %h want 0", rsp_rdata); end
    vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err got %b want 0", rsp_err); end
    vectors++; if (led !== 8'd0) begin miscompares++; $display("[TB] FAIL reset_led got %h want 0", led); end
    rst = 1'b0;
  endtask

  task automatic test_latency();
    logic [31:0] rd;
    logic        er;
    int          lat;
    req_valid  = 1'b1;
    req_wen    = 1'b1;
    req_addr   = 32'h10;
    req_wdata  = 32'hDEADBEEF;
    req_funct3 = F_W;
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL lat_ready_c0 got %b want 1", req_ready); end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    vectors++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL lat_c1 ready=%b valid=%b want 0/0", req_ready, rsp_valid); end
    @(negedge clk);
    vectors++; if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL lat_c2 valid=%b ready=%b want 1/0", rsp_valid, req_ready); end
    vectors++; if (rsp_err !== 1'b0 || rsp_rdata !== 32'd0) begin miscompares++; $display("[TB] FAIL lat_c2_data err=%b rdata=%h want 0/0", rsp_err, rsp_rdata); end
    @(negedge clk);
    vectors++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL lat_c3 ready=%b valid=%b want 1/0", req_ready, rsp_valid); end
    do_txn(1'b0, 32'h10, 32'd0, F_W, rd, er, lat);
    vectors++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin miscompares++; $display("[TB] FAIL lw_10 got %h err=%b want deadbeef/0", rd, er); end
    vectors++; if (lat !== 2) begin miscompares++; $display("[TB] FAIL lw_latency got %0d want 2", lat); end
  endtask

  task automatic test_load_ext();
    logic [31:0] addrs [4];
    logic [2:0]  f3s [4];
    logic [31:0] exps [4];
    logic [31:0] rd;
    logic        er;
    int          lat;
    addrs = '{32'h13, 32'h13, 32'h10, 32'h12};
    f3s   = '{F_B, F_BU, F_H, F_HU};
    exps  = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFBEEF, 32'h0000DEAD};
    for (int i = 0; i < 4; i++) begin
      do_txn(1'b0, addrs[i], 32'd0, f3s[i], rd, er, lat);
      vectors++;
      if (rd !== exps[i] || er !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL load_ext[%0d] f3=%b addr=%h got %h err=%b want %h/0", i, f3s[i], addrs[i], rd, er, exps[i]);
      end
    end
  endtask

  task automatic test_store_merge();
    logic [31:0] rd;
    logic        er;
    int          lat;
    do_txn(1'b1, 32'h11, 32'h00000055, F_B, rd, er, lat);
    do_txn(1'b0, 32'h10, 32'd0, F_W, rd, er, lat);
    vectors++; if (rd !== 32'hDEAD55EF) begin miscompares++; $display("[TB] FAIL sb_merge got %h want dead55ef", rd); end
    do_txn(1'b1, 32'h12, 32'h00001234, F_H, rd, er, lat);
    do_txn(1'b0, 32'h10, 32'd0, F_W, rd, er, lat);
    vectors++; if (rd !== 32'h123455EF) begin miscompares++; $display("[TB] FAIL sh_merge got %h want 123455ef", rd); end
  endtask

  task automatic test_errors();
    logic        wens [6];
    logic [31:0] addrs [6];
    logic [2:0]  f3s [6];
    logic [31:0] rd;
    logic        er;
    int          lat;
    wens  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    addrs = '{32'h12, 32'h11, 32'h10, 32'h1000, 32'h1000, 32'h10};
    f3s   = '{F_W, F_H, 3'b011, F_W, F_W, F_BU};
    for (int i = 0; i < 6; i++) begin
      do_txn(wens[i], addrs[i], 32'hFFFFFFFF, f3s[i], rd, er, lat);
      vectors++;
      if (er !== 1'b1 || rd !== 32'd0) begin
        miscompares++;
        $display("[TB] FAIL err_case[%0d] got err=%b rdata=%h want 1/0", i, er, rd);
      end
    end
    do_txn(1'b0, 32'h10, 32'd0, F_W, rd, er, lat);
    vectors++; if (rd !== 32'h123455EF) begin miscompares++; $display("[TB] FAIL err_ram_kept got %h want 123455ef", rd); end
    vectors++; if (led !== 8'd0) begin miscompares++; $display("[TB] FAIL err_led_kept got %h want 0", led); end
  endtask

  task automatic test_led();
    logic [31:0] rd;
    logic        er;
    int          lat;
    do_txn(1'b1, LED_ADDR, 32'h000000A5, F_W, rd, er, lat);
    vectors++; if (led !== 8'd0) begin miscompares++; $display("[TB] FAIL led_before_commit got %h want 0", led); end
    @(negedge clk);
    vectors++; if (led !== 8'hA5) begin miscompares++; $display("[TB] FAIL led_write got %h want a5", led); end
    do_txn(1'b0, LED_ADDR, 32'd0, F_B, rd, er, lat);
    vectors++; if (rd !== 32'h000000A5 || er !== 1'b0) begin miscompares++; $display("[TB] FAIL led_lb got %h err=%b want 000000a5/0", rd, er); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          pulses;
    do_txn(1'b1, 32'h20, 32'h0, F_W, rd, er, lat);
    @(negedge clk);
    req_valid  = 1'b1;
    req_wen    = 1'b1;
    req_addr   = 32'h20;
    req_wdata  = 32'h1;
    req_funct3 = F_W;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    vectors++; if (pulses !== 0) begin miscompares++; $display("[TB] FAIL abort_no_rsp got %0d pulses want 0", pulses); end
    vectors++; if (led !== 8'd0) begin miscompares++; $display("[TB] FAIL abort_led got %h want 0", led); end
    do_txn(1'b0, 32'h20, 32'd0, F_W, rd, er, lat);
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("[TB] FAIL abort_no_commit got %h want 0", rd); end
  endtask

  task automatic test_back_to_back();
    int accepts;
    int pulses;
    accepts = 0;
    pulses  = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) begin
        req_valid  = 1'b1;
        req_wen    = 1'b0;
        req_addr   = 32'h10;
        req_funct3 = F_W;
      end
      if (req_ready) accepts++;
      if (rsp_valid) begin
        pulses++;
        vectors++;
        if (rsp_rdata !== 32'h123455EF) begin miscompares++; $display("[TB] FAIL b2b_data got %h want 123455ef", rsp_rdata); end
      end
    end
    req_valid = 1'b0;
    vectors++; if (accepts !== 4) begin miscompares++; $display("[TB] FAIL b2b_accepts got %0d want 4", accepts); end
    vectors++; if (pulses !== 4) begin miscompares++; $display("[TB] FAIL b2b_pulses got %0d want 4", pulses); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_load_ext();
    test_store_merge();
    test_errors();
    test_led();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
